i2c_slave_rx: RTL and testbench

- Single-address I2C target (write-only receiver) answering transfers from the team's I2C master.
- Oversamples SCL/SDA on the system clock, detects START, repeated START and STOP, matches the 7-bit address and ACKs it.
- Shifts in data bytes MSB first and presents each byte on a valid/ready handshake.
- No clock stretching; SCL is input only.

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_line_sync.sv | 31 +++
 rtl/i2c_slave_rx.sv | 183 ++++++++++++++++++
 tb/tb_i2c_slave_rx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C constants and receiver state encoding
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;
  localparam int I2C_CNT_W  = 3;

  localparam logic                 I2C_WRITE   = 1'b0;
  localparam logic [I2C_CNT_W-1:0] BIT_CNT_MAX = 3'd7;

  // 8-bit encoding keeps state width identical to the master's
  typedef enum logic [7:0] {
    IDLE      = 8'd0,
    ADDR      = 8'd1,
    ADDR_ACK  = 8'd2,
    DATA      = 8'd3,
    DATA_ACK  = 8'd4,
    DATA_NACK = 8'd5,
    IGNORE    = 8'd6
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - synchronizer plus history flop with rise/fall detection
module i2c_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Reset to the idle-high bus level so no edge appears after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], line_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~hist_q;
  assign fall_o  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/i2c_slave_rx.sv
// rtl/i2c_slave_rx.sv - single-address write-only I2C target with byte handshake
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] DEV_ADDR    = 7'h50,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCL,
  inout  wire                   SDA,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_overrun,
  output logic                  addr_match,
  output logic                  busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk    (clk),
    .reset  (reset),
    .line_i (SCL),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk    (clk),
    .reset  (reset),
    .line_i (SDA),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  i2c_state_e                state_q, state_d;
  logic [I2C_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [I2C_BYTE_W-1:0]     shift_q, shift_d;
  logic [I2C_BYTE_W-1:0]     rx_data_q, rx_data_d;
  logic                      phase_q, phase_d;
  logic                      sda_oe_q, sda_oe_d;
  logic                      rx_valid_q, rx_valid_d;
  logic                      rx_overrun_q, rx_overrun_d;
  logic                      addr_match_q, addr_match_d;
  logic                      busy_q, busy_d;

  logic [I2C_BYTE_W-1:0]     byte_in;
  logic                      in_ack, start_det, stop_det, last_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= BIT_CNT_MAX;
      shift_q      <= '0;
      rx_data_q    <= '0;
      phase_q      <= 1'b0;
      sda_oe_q     <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      addr_match_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      phase_q      <= phase_d;
      sda_oe_q     <= sda_oe_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      addr_match_q <= addr_match_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    phase_d      = phase_q;
    sda_oe_d     = sda_oe_q;
    rx_valid_d   = 1'b0;
    rx_overrun_d = 1'b0;
    addr_match_d = addr_match_q;
    busy_d       = busy_q;

    byte_in   = {shift_q[I2C_BYTE_W-2:0], sda_lvl};
    last_bit  = scl_rise && (bit_cnt_q == '0);
    // Our own ACK pulls SDA, so bus conditions are not trusted during ACK states
    in_ack    = (state_q == ADDR_ACK) || (state_q == DATA_ACK);
    start_det = sda_fall && scl_lvl && !in_ack;
    stop_det  = sda_rise && scl_lvl && !in_ack;

    if (scl_rise && (state_q == ADDR || state_q == DATA)) begin
      shift_d   = byte_in;
      bit_cnt_d = bit_cnt_q - 1'b1;
    end

    case (state_q)
      ADDR: begin
        if (last_bit) begin
          if (byte_in[I2C_BYTE_W-1:1] == DEV_ADDR && byte_in[0] == I2C_WRITE) begin
            addr_match_d = 1'b1;
            state_d      = ADDR_ACK;
          end else begin
            state_d = IGNORE;
          end
        end
      end
      ADDR_ACK, DATA_ACK: begin
        // First fall starts the ACK bit, second fall ends it
        if (scl_fall) begin
          if (!phase_q) begin
            phase_d  = 1'b1;
            sda_oe_d = 1'b1;
          end else begin
            phase_d   = 1'b0;
            sda_oe_d  = 1'b0;
            bit_cnt_d = BIT_CNT_MAX;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (last_bit) begin
          if (rx_ready) begin
            rx_data_d  = byte_in;
            rx_valid_d = 1'b1;
            state_d    = DATA_ACK;
          end else begin
            rx_overrun_d = 1'b1;
            state_d      = DATA_NACK;
          end
        end
      end
      DATA_NACK: begin
        if (scl_fall) begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            state_d = IGNORE;
          end
        end
      end
      default: ;
    endcase

    if (start_det) begin
      state_d      = ADDR;
      bit_cnt_d    = BIT_CNT_MAX;
      phase_d      = 1'b0;
      sda_oe_d     = 1'b0;
      rx_valid_d   = 1'b0;
      rx_overrun_d = 1'b0;
      addr_match_d = 1'b0;
      busy_d       = 1'b1;
    end else if (stop_det) begin
      state_d      = IDLE;
      bit_cnt_d    = BIT_CNT_MAX;
      phase_d      = 1'b0;
      sda_oe_d     = 1'b0;
      rx_valid_d   = 1'b0;
      rx_overrun_d = 1'b0;
      addr_match_d = 1'b0;
      busy_d       = 1'b0;
    end
  end

  assign SDA        = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_overrun_q;
  assign addr_match = addr_match_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// tb/tb_i2c_slave_rx.sv - directed self-checking bench for i2c_slave_rx
module tb_i2c_slave_rx;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       tb_sda_low = 1'b0;
  logic       rx_ready = 1'b1;
  wire        sda_line;
  logic [7:0] rx_data;
  logic       rx_valid, rx_overrun, addr_match, busy;

  int checks = 0;
  int errors = 0;

  int         valid_cnt = 0;
  int         ovr_cnt = 0;
  int         both_cnt = 0;
  int         drive_cnt = 0;
  logic [7:0] last_data = 8'h00;

  always #5 clk = ~clk;

  assign sda_line = tb_sda_low ? 1'b0 : 1'bz;
  pullup (sda_line);

  i2c_slave_rx #(.DEV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .SCL       (scl),
    .SDA       (sda_line),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_overrun(rx_overrun),
    .addr_match(addr_match),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt = valid_cnt + 1;
      last_data = rx_data;
    end
    if (rx_overrun) ovr_cnt = ovr_cnt + 1;
    if (rx_valid && rx_overrun) both_cnt = both_cnt + 1;
    if (!tb_sda_low && sda_line === 1'b0) drive_cnt = drive_cnt + 1;
  end

  task automatic wait_q(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic start_cond();
    tb_sda_low = 1'b0; wait_q(1);
    scl = 1'b1;        wait_q(1);
    tb_sda_low = 1'b1; wait_q(1);
    scl = 1'b0;        wait_q(1);
  endtask

  task automatic stop_cond();
    wait_q(1); tb_sda_low = 1'b1;
    wait_q(1); scl = 1'b1;
    wait_q(1); tb_sda_low = 1'b0;
    wait_q(1);
  endtask

  task automatic send_bit(input logic b);
    wait_q(1); tb_sda_low = ~b;
    wait_q(1); scl = 1'b1;
    wait_q(2); scl = 1'b0;
  endtask

  task automatic ack_bit(output logic acked);
    wait_q(1); tb_sda_low = 1'b0;
    wait_q(1); scl = 1'b1;
    wait_q(1); acked = (sda_line === 1'b0);
    wait_q(1); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    ack_bit(acked);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (sda_line !== 1'b1) begin errors++; $display("FAIL reset_sda got %b expected 1", sda_line); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h expected 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b expected 0", rx_valid); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_rx_overrun got %b expected 0", rx_overrun); end
    checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL reset_addr_match got %b expected 0", addr_match); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic_write();
    logic a;
    int v0;
    v0 = valid_cnt;
    rx_ready = 1'b1;
    start_cond();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start got %b expected 1", busy); end
    send_byte(8'hA0, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL basic_addr_ack got %b expected 1", a); end
    checks++; if (addr_match !== 1'b1) begin errors++; $display("FAIL basic_addr_match got %b expected 1", addr_match); end
    send_byte(8'h3C, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL basic_data_ack got %b expected 1", a); end
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL basic_valid_count got %0d expected 1", valid_cnt - v0); end
    checks++; if (last_data !== 8'h3C) begin errors++; $display("FAIL basic_valid_data got %h expected 3c", last_data); end
    stop_cond();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_stop got %b expected 0", busy); end
    checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL basic_match_stop got %b expected 0", addr_match); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL basic_rx_data got %h expected 3c", rx_data); end
  endtask

  task automatic test_wrong_addr();
    logic a;
    int v0, d0;
    v0 = valid_cnt; d0 = drive_cnt;
    start_cond();
    send_byte(8'hA2, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL wrong_addr_ack got %b expected 0", a); end
    checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL wrong_addr_match got %b expected 0", addr_match); end
    send_byte(8'hFF, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL wrong_data_ack got %b expected 0", a); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wrong_busy got %b expected 1", busy); end
    checks++; if (drive_cnt - d0 !== 0) begin errors++; $display("FAIL wrong_sda_driven got %0d cycles expected 0", drive_cnt - d0); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL wrong_valid got %0d expected 0", valid_cnt - v0); end
    stop_cond();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrong_busy_stop got %b expected 0", busy); end
  endtask

  task automatic test_read_request();
    logic a;
    int v0;
    v0 = valid_cnt;
    start_cond();
    send_byte(8'hA1, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL read_nack got %b expected 0", a); end
    checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL read_match got %b expected 0", addr_match); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL read_valid got %0d expected 0", valid_cnt - v0); end
    start_cond();
    send_byte(8'hA0, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL read_restart_ack got %b expected 1", a); end
    send_byte(8'h55, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL read_data_ack got %b expected 1", a); end
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL read_rx_data got %h expected 55", rx_data); end
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL read_valid_after got %0d expected 1", valid_cnt - v0); end
    stop_cond();
  endtask

  task automatic test_overrun();
    logic a;
    int v0, o0, b0;
    v0 = valid_cnt; o0 = ovr_cnt; b0 = both_cnt;
    rx_ready = 1'b1;
    start_cond();
    send_byte(8'hA0, a);
    send_byte(8'h12, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL ovr_first_ack got %b expected 1", a); end
    rx_ready = 1'b0;
    send_byte(8'h34, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL ovr_second_nack got %b expected 0", a); end
    checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulse_count got %0d expected 1", ovr_cnt - o0); end
    checks++; if (rx_data !== 8'h12) begin errors++; $display("FAIL ovr_rx_data got %h expected 12", rx_data); end
    checks++; if (addr_match !== 1'b1) begin errors++; $display("FAIL ovr_match_held got %b expected 1", addr_match); end
    rx_ready = 1'b1;
    send_byte(8'h56, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL ovr_ignored_ack got %b expected 0", a); end
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL ovr_valid_count got %0d expected 1", valid_cnt - v0); end
    checks++; if (both_cnt - b0 !== 0) begin errors++; $display("FAIL ovr_exclusive got %0d expected 0", both_cnt - b0); end
    stop_cond();
    checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL ovr_match_stop got %b expected 0", addr_match); end
  endtask

  task automatic test_repeated_start();
    logic a;
    int v0;
    logic [7:0] partial;
    partial = 8'hB0;
    start_cond();
    send_byte(8'hA0, a);
    v0 = valid_cnt;
    for (int i = 7; i >= 4; i--) send_bit(partial[i]);
    start_cond();
    checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL rs_match_cleared got %b expected 0", addr_match); end
    send_byte(8'hA0, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL rs_addr_ack got %b expected 1", a); end
    send_byte(8'h9A, a);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL rs_valid_count got %0d expected 1", valid_cnt - v0); end
    checks++; if (last_data !== 8'h9A) begin errors++; $display("FAIL rs_data got %h expected 9a", last_data); end
    stop_cond();
  endtask

  task automatic test_reset_mid_ack();
    logic a;
    logic [7:0] addr;
    int v0;
    addr = 8'hA0;
    start_cond();
    for (int i = 7; i >= 0; i--) send_bit(addr[i]);
    wait_q(1); tb_sda_low = 1'b0;
    wait_q(1);
    checks++; if (sda_line !== 1'b0) begin errors++; $display("FAIL rst_ack_driven got %b expected 0", sda_line); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (sda_line !== 1'b1) begin errors++; $display("FAIL rst_sda_released got %b expected 1", sda_line); end
    checks++; if (addr_match !== 1'b0) begin errors++; $display("FAIL rst_addr_match got %b expected 0", addr_match); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b expected 0", busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data got %h expected 00", rx_data); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    v0 = valid_cnt;
    start_cond();
    send_byte(8'hA0, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL rst_next_addr_ack got %b expected 1", a); end
    send_byte(8'h77, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL rst_next_data_ack got %b expected 1", a); end
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL rst_next_valid got %0d expected 1", valid_cnt - v0); end
    checks++; if (rx_data !== 8'h77) begin errors++; $display("FAIL rst_next_data got %h expected 77", rx_data); end
    stop_cond();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_next_busy got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_wrong_addr();
    test_read_request();
    test_overrun();
    test_repeated_start();
    test_reset_mid_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
